// File: rtl/model_tensor_oneplus_function.sv
// Streams a 3-D tensor one element at a time and applies softplus or oneplus
// (softplus + 1.0, saturating) in signed fixed point, flagging i/j/k index advance.
module model_tensor_oneplus_function #(
    parameter int DATA_SIZE      = 64,
    parameter int FRACTION_SIZE  = 32,
    parameter int CONTROL_SIZE   = 4,
    parameter int THRESHOLD_LOG2 = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic                    MODE,
    input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic                    DATA_OUT_K_ENABLE
);

    // state   | meaning
    // STARTER | idle, waiting for START (ignored while READY pulses)
    // INPUT   | waiting for DATA_IN_ENABLE to capture one element
    // COMPUTE | registered arithmetic stage
    // OUTPUT  | strobe result, advance k/j/i, finish on last element
    typedef enum logic [1:0] {
        ST_STARTER = 2'd0,
        ST_INPUT   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam int SHIFT = FRACTION_SIZE + THRESHOLD_LOG2 + 2;
    localparam logic [DATA_SIZE-1:0] P_ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRACTION_SIZE;
    localparam logic [DATA_SIZE-1:0] P_T   = {{(DATA_SIZE-1){1'b0}}, 1'b1} << (FRACTION_SIZE + THRESHOLD_LOG2);
    localparam logic [DATA_SIZE-1:0] P_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};

    state_t                  r_state;
    logic                    r_mode;
    logic [CONTROL_SIZE-1:0] r_size_i, r_size_j, r_size_k;
    logic [CONTROL_SIZE-1:0] r_i, r_j, r_k;
    logic [DATA_SIZE-1:0]    r_data;
    logic [DATA_SIZE-1:0]    r_result;

    logic                    w_ge, w_le;
    logic [DATA_SIZE-1:0]    w_bias;
    logic [2*DATA_SIZE-1:0]  w_bias_wide, w_square;
    logic [DATA_SIZE-1:0]    w_knee, w_soft, w_sat, w_result;
    logic [DATA_SIZE:0]      w_sum;
    logic                    w_size_zero;
    logic                    w_k_last, w_j_last, w_i_last;

    // Between the knees x+T lies in (0, 2T), so it is treated as unsigned before squaring.
    assign w_ge        = $signed(r_data) >= $signed(P_T);
    assign w_le        = $signed(r_data) <= -$signed(P_T);
    assign w_bias      = r_data + P_T;
    assign w_bias_wide = {{DATA_SIZE{1'b0}}, w_bias};
    assign w_square    = w_bias_wide * w_bias_wide;
    assign w_knee      = DATA_SIZE'(w_square >> SHIFT);
    assign w_soft      = w_ge ? r_data : (w_le ? '0 : w_knee);
    assign w_sum       = {1'b0, w_soft} + {1'b0, P_ONE};
    assign w_sat       = (w_sum > {1'b0, P_MAX}) ? P_MAX : w_sum[DATA_SIZE-1:0];
    assign w_result    = r_mode ? w_sat : w_soft;

    assign w_size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);
    assign w_k_last    = (r_k == r_size_k - CONTROL_SIZE'(1));
    assign w_j_last    = (r_j == r_size_j - CONTROL_SIZE'(1));
    assign w_i_last    = (r_i == r_size_i - CONTROL_SIZE'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state           <= ST_STARTER;
            r_mode            <= 1'b0;
            r_size_i          <= '0;
            r_size_j          <= '0;
            r_size_k          <= '0;
            r_i               <= '0;
            r_j               <= '0;
            r_k               <= '0;
            r_data            <= '0;
            r_result          <= '0;
            READY             <= 1'b0;
            DATA_OUT_ENABLE   <= 1'b0;
            DATA_OUT          <= '0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT_K_ENABLE <= 1'b0;
        end else begin
            READY             <= 1'b0;
            DATA_OUT_ENABLE   <= 1'b0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT_K_ENABLE <= 1'b0;
            case (r_state)
                ST_STARTER: begin
                    if (START && !READY) begin
                        r_mode   <= MODE;
                        r_size_i <= SIZE_I_IN;
                        r_size_j <= SIZE_J_IN;
                        r_size_k <= SIZE_K_IN;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        if (w_size_zero) begin
                            READY <= 1'b1;
                        end else begin
                            r_state <= ST_INPUT;
                        end
                    end
                end
                ST_INPUT: begin
                    if (DATA_IN_ENABLE) begin
                        r_data  <= DATA_IN;
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_result <= w_result;
                    r_state  <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    DATA_OUT          <= r_result;
                    DATA_OUT_ENABLE   <= 1'b1;
                    DATA_OUT_K_ENABLE <= 1'b1;
                    r_state           <= ST_INPUT;
                    if (w_k_last) begin
                        r_k               <= '0;
                        DATA_OUT_J_ENABLE <= 1'b1;
                        if (w_j_last) begin
                            r_j               <= '0;
                            DATA_OUT_I_ENABLE <= 1'b1;
                            if (w_i_last) begin
                                r_i     <= '0;
                                READY   <= 1'b1;
                                r_state <= ST_STARTER;
                            end else begin
                                r_i <= r_i + CONTROL_SIZE'(1);
                            end
                        end else begin
                            r_j <= r_j + CONTROL_SIZE'(1);
                        end
                    end else begin
                        r_k <= r_k + CONTROL_SIZE'(1);
                    end
                end
                default: r_state <= ST_STARTER;
            endcase
        end
    end

endmodule

// File: tb/tb_model_tensor_oneplus_function.sv
// Directed bench for model_tensor_oneplus_function at 16-bit Q8.8, knee T = 2.0.
module tb_model_tensor_oneplus_function;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic        MODE;
    logic [3:0]  SIZE_I_IN, SIZE_J_IN, SIZE_K_IN;
    logic        DATA_IN_ENABLE;
    logic [15:0] DATA_IN;
    logic        DATA_OUT_ENABLE;
    logic [15:0] DATA_OUT;
    logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE;

    int n_checks = 0;
    int n_fail   = 0;

    model_tensor_oneplus_function #(
        .DATA_SIZE(16), .FRACTION_SIZE(8), .CONTROL_SIZE(4), .THRESHOLD_LOG2(1)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .MODE(MODE),
        .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .SIZE_K_IN(SIZE_K_IN),
        .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_IN(DATA_IN),
        .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT),
        .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
        .DATA_OUT_K_ENABLE(DATA_OUT_K_ENABLE)
    );

    always #5 CLK = ~CLK;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_tensor(input logic m, input logic [3:0] si, input logic [3:0] sj, input logic [3:0] sk);
        START = 1'b1; MODE = m; SIZE_I_IN = si; SIZE_J_IN = sj; SIZE_K_IN = sk;
        tick;
        START = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] obs;
        obs = {READY, DATA_OUT_ENABLE, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE, DATA_OUT};
        n_checks++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        RST = 1'b0;
        tick;
    endtask

    task automatic test_function;
        logic        t_mode [13];
        logic [15:0] t_in   [13];
        logic [15:0] t_exp  [13];
        t_mode = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t_in   = '{16'h0000, 16'h0100, 16'h0300, 16'hFD00, 16'h7F00, 16'hFF00, 16'h7EFF,
                   16'h0000, 16'h01FF, 16'h0200, 16'hFE00, 16'hFF00, 16'h7F00};
        t_exp  = '{16'h0180, 16'h0220, 16'h0400, 16'h0100, 16'h7FFF, 16'h0120, 16'h7FFF,
                   16'h0080, 16'h01FF, 16'h0200, 16'h0000, 16'h0020, 16'h7F00};
        for (int v = 0; v < 13; v++) begin
            start_tensor(t_mode[v], 4'd1, 4'd1, 4'd1);
            DATA_IN = t_in[v]; DATA_IN_ENABLE = 1'b1;
            tick;
            DATA_IN_ENABLE = 1'b0;
            n_checks++;
            if (DATA_OUT_ENABLE !== 1'b0) begin
                n_fail++;
                $display("FAIL func_early1 #%0d: DATA_OUT_ENABLE=%b, want 0", v, DATA_OUT_ENABLE);
            end
            tick;
            n_checks++;
            if (DATA_OUT_ENABLE !== 1'b0) begin
                n_fail++;
                $display("FAIL func_early2 #%0d: DATA_OUT_ENABLE=%b, want 0", v, DATA_OUT_ENABLE);
            end
            tick;
            n_checks++;
            if ({DATA_OUT_ENABLE, READY, DATA_OUT} !== {1'b1, 1'b1, t_exp[v]}) begin
                n_fail++;
                $display("FAIL func_result #%0d mode=%b in=%h: en=%b ready=%b out=%h, want en=1 ready=1 out=%h",
                         v, t_mode[v], t_in[v], DATA_OUT_ENABLE, READY, DATA_OUT, t_exp[v]);
            end
            tick;
            n_checks++;
            if ({DATA_OUT_ENABLE, READY, DATA_OUT} !== {1'b0, 1'b0, t_exp[v]}) begin
                n_fail++;
                $display("FAIL func_hold #%0d: en=%b ready=%b out=%h, want en=0 ready=0 out=%h",
                         v, DATA_OUT_ENABLE, READY, DATA_OUT, t_exp[v]);
            end
        end
    endtask

    task automatic test_tensor_223(input string tag);
        logic [4:0]  obs, exp;
        logic [15:0] exp_d;
        start_tensor(1'b1, 4'd2, 4'd2, 4'd3);
        for (int n = 0; n < 12; n++) begin
            DATA_IN = 16'((n + 2) << 8); DATA_IN_ENABLE = 1'b1;
            exp_d   = 16'((n + 3) << 8);
            tick;
            DATA_IN_ENABLE = 1'b0;
            tick;
            n_checks++;
            if (DATA_OUT_ENABLE !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_gap #%0d: DATA_OUT_ENABLE=%b, want 0", tag, n, DATA_OUT_ENABLE);
            end
            tick;
            obs = {DATA_OUT_ENABLE, DATA_OUT_K_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_I_ENABLE, READY};
            exp = {1'b1, 1'b1, (n % 3 == 2), (n % 6 == 5), (n == 11)};
            n_checks++;
            if (obs !== exp || DATA_OUT !== exp_d) begin
                n_fail++;
                $display("FAIL %s_elem #%0d: {en,k,j,i,ready}=%b out=%h, want %b out=%h",
                         tag, n, obs, DATA_OUT, exp, exp_d);
            end
        end
        tick;
        n_checks++;
        if ({DATA_OUT_ENABLE, READY, DATA_OUT_K_ENABLE} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_after: en=%b ready=%b k=%b, want 000", tag, DATA_OUT_ENABLE, READY, DATA_OUT_K_ENABLE);
        end
    endtask

    task automatic test_size_zero;
        start_tensor(1'b1, 4'd2, 4'd0, 4'd3);
        n_checks++;
        if ({READY, DATA_OUT_ENABLE} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_ready: ready=%b en=%b, want ready=1 en=0", READY, DATA_OUT_ENABLE);
        end
        DATA_IN = 16'h0100; DATA_IN_ENABLE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            n_checks++;
            if ({READY, DATA_OUT_ENABLE} !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_idle cycle %0d: ready=%b en=%b, want 00", c, READY, DATA_OUT_ENABLE);
            end
        end
        DATA_IN_ENABLE = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        start_tensor(1'b1, 4'd1, 4'd1, 4'd1);
        DATA_IN = 16'h0100; DATA_IN_ENABLE = 1'b1;
        tick;
        DATA_IN_ENABLE = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({READY, DATA_OUT} !== {1'b1, 16'h0220}) begin
            n_fail++;
            $display("FAIL b2b_first: ready=%b out=%h, want ready=1 out=0220", READY, DATA_OUT);
        end
        // START during the READY cycle must not open a tensor
        start_tensor(1'b1, 4'd1, 4'd1, 4'd1);
        DATA_IN = 16'h0300; DATA_IN_ENABLE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_checks++;
            if (DATA_OUT_ENABLE !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ignored cycle %0d: DATA_OUT_ENABLE=%b, want 0", c, DATA_OUT_ENABLE);
            end
        end
        DATA_IN_ENABLE = 1'b0;
        start_tensor(1'b0, 4'd1, 4'd1, 4'd1);
        DATA_IN = 16'hFF00; DATA_IN_ENABLE = 1'b1;
        tick;
        DATA_IN_ENABLE = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({DATA_OUT_ENABLE, READY, DATA_OUT} !== {1'b1, 1'b1, 16'h0020}) begin
            n_fail++;
            $display("FAIL b2b_second: en=%b ready=%b out=%h, want en=1 ready=1 out=0020",
                     DATA_OUT_ENABLE, READY, DATA_OUT);
        end
        tick;
    endtask

    task automatic test_continuous;
        logic exp_en;
        start_tensor(1'b1, 4'd1, 4'd1, 4'd3);
        for (int c = 0; c < 12; c++) begin
            exp_en = (c == 3) || (c == 6) || (c == 9);
            n_checks++;
            if (DATA_OUT_ENABLE !== exp_en || READY !== (c == 9) ||
                (exp_en && DATA_OUT !== 16'(c << 8))) begin
                n_fail++;
                $display("FAIL cont cycle %0d: en=%b ready=%b out=%h, want en=%b ready=%b out=%h",
                         c, DATA_OUT_ENABLE, READY, DATA_OUT, exp_en, (c == 9), 16'(c << 8));
            end
            DATA_IN = 16'((c + 2) << 8); DATA_IN_ENABLE = 1'b1;
            START = (c >= 3 && c <= 5);
            tick;
        end
        DATA_IN_ENABLE = 1'b0; START = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int n_out = 0;
        start_tensor(1'b1, 4'd2, 4'd2, 4'd3);
        for (int n = 0; n < 5; n++) begin
            DATA_IN = 16'h0400; DATA_IN_ENABLE = 1'b1;
            tick;
            DATA_IN_ENABLE = 1'b0;
            tick;
            tick;
            if (DATA_OUT_ENABLE === 1'b1) n_out++;
        end
        n_checks++;
        if (n_out != 5 || DATA_OUT !== 16'h0500) begin
            n_fail++;
            $display("FAIL mid_prefix: outputs=%0d out=%h, want 5 outputs out=0500", n_out, DATA_OUT);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({DATA_OUT_ENABLE, DATA_OUT_K_ENABLE, READY, DATA_OUT} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: en=%b k=%b ready=%b out=%h, want all 0",
                     DATA_OUT_ENABLE, DATA_OUT_K_ENABLE, READY, DATA_OUT);
        end
        tick;
        RST = 1'b0;
        DATA_IN = 16'h0400; DATA_IN_ENABLE = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            n_checks++;
            if ({READY, DATA_OUT_ENABLE} !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_idle cycle %0d: ready=%b en=%b, want 00", c, READY, DATA_OUT_ENABLE);
            end
        end
        DATA_IN_ENABLE = 1'b0;
        tick;
        test_tensor_223("mid_rerun");
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; MODE = 1'b0;
        SIZE_I_IN = '0; SIZE_J_IN = '0; SIZE_K_IN = '0;
        DATA_IN_ENABLE = 1'b0; DATA_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset;
        test_function;
        test_tensor_223("t223");
        test_size_zero;
        test_back_to_back;
        test_continuous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
